// File: rtl/regfile_pkg.sv
// Shared register-file dimensions and the write-arbiter state encoding.
package regfile_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side write bus: per-requester valid/last/addr/data, one-hot ready, and a global hold.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = regfile_pkg::ADDR_W,
   parameter int DATA_W  = regfile_pkg::DATA_W
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      hold;

   modport master (
      output req_valid, req_last, req_addr, req_data, hold,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_last, req_addr, req_data, hold,
      output req_ready
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping to index 0.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_grant
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      // First pass covers ptr..top; the second only fires for indices below ptr (the wrap).
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_grant && req[i] && (ID_W'(i) >= ptr)) begin
            any_grant = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_grant && req[i]) begin
            any_grant = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter with burst lock in front of the register-file write port,
// plus read-after-write hazard flags and forwarding data for the write on the port.
module regfile_write_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ADDR_W  = regfile_pkg::ADDR_W,
   parameter  int DATA_W  = regfile_pkg::DATA_W,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   regfile_write_arbiter_if.slave req_bus,
   output logic                  rf_write_enable,
   output logic [ADDR_W-1:0]     rf_write_address,
   output logic [DATA_W-1:0]     rf_data_in,
   input  logic [ADDR_W-1:0]     rd_addr_1,
   input  logic [ADDR_W-1:0]     rd_addr_2,
   output logic                  rd_hazard_1,
   output logic                  rd_hazard_2,
   output logic [DATA_W-1:0]     rd_fwd_data,
   output logic [ID_W-1:0]       grant_id
);
   import regfile_pkg::*;

   arb_state_t          state, state_nxt;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]     lock_id, lock_id_nxt;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [ID_W-1:0]     arb_idx;
   logic                arb_any;
   logic [NUM_REQ-1:0]  ready;
   logic                xfer;
   logic [ID_W-1:0]     win_id;
   logic                win_last;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;

   logic                vld_p1;
   logic [ADDR_W-1:0]   addr_p1;
   logic [DATA_W-1:0]   data_p1;
   logic [ID_W-1:0]     id_p1;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
   endfunction

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_bus.req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_grant (arb_any)
   );

   // Stage p0: grant selection, combinational from the current request vector.
   always_comb begin
      ready = '0;
      xfer  = 1'b0;
      if (reset_n && !req_bus.hold) begin
         if (state == ARB_IDLE) begin
            ready = arb_grant;
            xfer  = arb_any;
         end else begin
            ready[lock_id] = req_bus.req_valid[lock_id];
            xfer           = req_bus.req_valid[lock_id];
         end
      end
   end

   assign req_bus.req_ready = ready;
   assign win_id            = (state == ARB_IDLE) ? arb_idx : lock_id;

   always_comb begin
      win_last = 1'b0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ready[i]) begin
            win_last = req_bus.req_last[i];
            win_addr = req_bus.req_addr[i*ADDR_W +: ADDR_W];
            win_data = req_bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      lock_id_nxt = lock_id;
      if (xfer) begin
         unique case (state)
            ARB_IDLE: begin
               if (win_last) begin
                  rr_ptr_nxt = next_id(arb_idx);
               end else begin
                  state_nxt   = ARB_LOCKED;
                  lock_id_nxt = arb_idx;
               end
            end
            ARB_LOCKED: begin
               if (win_last) begin
                  state_nxt  = ARB_IDLE;
                  rr_ptr_nxt = next_id(lock_id);
               end
            end
            default: state_nxt = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ARB_IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         lock_id <= lock_id_nxt;
      end
   end

   // Stage p1: accepted beat registered onto the register-file write port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         id_p1   <= '0;
      end else begin
         vld_p1 <= xfer;
         if (xfer) begin
            addr_p1 <= win_addr;
            data_p1 <= win_data;
            id_p1   <= win_id;
         end
      end
   end

   assign rf_write_enable  = vld_p1;
   assign rf_write_address = addr_p1;
   assign rf_data_in       = data_p1;
   assign grant_id         = id_p1;

   // The register file still returns the old value this cycle, so readers bypass from here.
   assign rd_hazard_1 = vld_p1 && (rd_addr_1 == addr_p1);
   assign rd_hazard_2 = vld_p1 && (rd_addr_2 == addr_p1);
   assign rd_fwd_data = data_p1;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates several write requesters onto the single write port of the 16x16 dual-port register file and registers the winning write into that port. Arbitration is round-robin, and multi-beat bursts lock the grant to one requester. The block also detects read-after-write hazards on both read ports and supplies forwarding data for the write in flight. It sits directly in front of the register file; execution units and the load path are its requesters.

## Interface
Parameters:
- NUM_REQ, 4: number of write requesters (2..8)
- ADDR_W, 4: register address width
- DATA_W, 16: register data width

Ports:
- clk  in  1: single clock; all state updates on its rising edge
- reset_n  in  1: reset, synchronous and active-low
- req_valid  in  NUM_REQ: per-requester write request
- req_last  in  NUM_REQ: marks the final beat of a request; a single-beat write has last=1
- req_addr  in  NUM_REQ*ADDR_W: packed write addresses, requester i at slice i
- req_data  in  NUM_REQ*DATA_W: packed write data
- req_ready  out  NUM_REQ: one-hot grant, combinational; a beat transfers when valid&ready
- hold  in  1: freezes arbitration; no beat is granted while high
- rf_write_enable  out  1: to register file write_enable
- rf_write_address  out  ADDR_W: to register file write_address
- rf_data_in  out  DATA_W: to register file data_in
- rd_addr_1, rd_addr_2  in  ADDR_W each: copies of the register file read addresses
- rd_hazard_1, rd_hazard_2  out  1 each: the read address matches the write currently on the port
- rd_fwd_data  out  DATA_W: equals rf_data_in; the bypass value for a hazarding read
- grant_id  out  $clog2(NUM_REQ): index of the requester whose write is on the port

## Operation
- Two states: IDLE and LOCKED.
- IDLE:
  - req_ready goes to the first valid requester, searching upward from rr_ptr with wrap-around.
  - Transfer with last=1: stay in IDLE; rr_ptr <= winner+1 mod NUM_REQ.
  - Transfer with last=0: go to LOCKED; lock_id <= winner.
- LOCKED:
  - Only requester lock_id can receive ready, and only while its valid is high.
  - Valid dropping mid-burst: stay LOCKED; no write is produced.
  - Transfer with last=1: go to IDLE; rr_ptr <= lock_id+1 mod NUM_REQ.
- hold=1: req_ready is all zeros; state, rr_ptr and lock_id are unchanged.
- Output stage: every transferred beat is registered into rf_write_enable=1, rf_write_address, rf_data_in and grant_id. With no transfer, rf_write_enable=0 and address, data and grant_id keep their previous values.
- Hazard: rd_hazard_x = rf_write_enable && (rd_addr_x == rf_write_address), combinational. Both flags may be high at once.
- Reset (reset_n=0 at a clock edge):
  - State IDLE, rr_ptr=0, lock_id=0.
  - rf_write_enable=0, rf_write_address=0, rf_data_in=0, grant_id=0.
  - A burst in progress is abandoned; a registered write pending at that edge is dropped.
  - req_ready is forced to 0 combinationally while reset_n=0.
- Addresses are ADDR_W bits and carry no range check; pointer arithmetic wraps modulo NUM_REQ.

## Timing
- Grant latency: 0 cycles; ready is asserted in the same cycle as valid.
- Write latency: 1 cycle; a beat accepted in cycle N is driven on the rf_* outputs in cycle N+1 and committed at the end of N+1.
- Throughput: one beat per cycle with no bubbles, including between back-to-back requests from different requesters.
- A hazard flag is valid in the cycle the write is on the port. The register file still returns the old value in that cycle, so consumers must select rd_fwd_data.
- Rotation after a single-beat grant to the last index: rr_ptr wraps to 0.
- Simultaneous events in one cycle:
  - hold=1 overrides all valids.
  - reset_n=0 overrides hold and any transfer.

## Structure
- Shared package regfile_pkg holds DATA_W, ADDR_W and NUM_REGS=16 defaults, plus the arbiter state enum arb_state_t {ARB_IDLE, ARB_LOCKED}.
- One sub-module, rr_arbiter: combinational, with inputs req vector and pointer and outputs one-hot grant, grant index and any-grant.
- The top level holds the FSM, rr_ptr, lock_id, the output register and the hazard compare.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with all valids high -> req_ready=0000, rf_write_enable=0, rf_write_address=0, rf_data_in=0.
- Round-robin: after reset, all 4 requesters stay valid with last=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rf_write_enable high from cycle 2 onward; grant_id lags the grant by one cycle.
- Burst lock:
  - Requester 2 sends a 3-beat burst to addresses 5, 6, 7 while requester 0 is valid; requester 2 drops valid for one cycle between beats 1 and 2.
  - Required: requester 0 gets no grant until after beat 3; one bubble with rf_write_enable=0; then requester 3, if valid, is granted before 0.
- hold: assert hold for 3 cycles mid-stream -> req_ready=0, rf_write_enable=0 one cycle later; the grant order resumes exactly where it stopped.
- Hazard and forward:
  - Write 16'hBEEF to register 9, with rd_addr_1=9 and rd_addr_2=3.
  - Required: in the write cycle rd_hazard_1=1, rd_hazard_2=0, rd_fwd_data=16'hBEEF; in the next cycle the register file reads 16'hBEEF at address 9.
- Reset mid-burst: pull reset_n low on beat 2 of a 4-beat burst from requester 1 -> state IDLE; the pending beat is not written; after release requester 0 wins first.
